// File: rtl/nl_pkg.sv
// Shared types and constants for the netlist loader: FSM states, error codes
// and the default gate descriptor layout.
package nl_pkg;

    localparam int unsigned S_DEFAULT = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ORDER    = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;

    typedef struct packed {
        logic [S_DEFAULT-1:0] in0;
        logic [S_DEFAULT-1:0] in1;
        logic [3:0]           truth;
    } gate_t;

endpackage

// File: rtl/netlist_loader_if.sv
// Valid/ready descriptor stream from the host/DMA into the netlist loader.
interface netlist_loader_if #(
    parameter int unsigned S = 20
);
    logic         wr_valid;
    logic         wr_ready;
    logic [S-1:0] wr_in0;
    logic [S-1:0] wr_in1;
    logic [3:0]   wr_logic;
    logic         wr_last;

    modport master (
        output wr_valid, wr_in0, wr_in1, wr_logic, wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_in0, wr_in1, wr_logic, wr_last,
        output wr_ready
    );
endinterface

// File: rtl/nl_ram.sv
// Simple dual-port netlist RAM: one write port, one registered read port with
// read-before-write behaviour on address collision.
module nl_ram #(
    parameter int unsigned AW = 20,
    parameter int unsigned DW = 44
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem[raddr];
    end

    // Only the output register is reset; the array itself keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/netlist_loader.sv
// Runtime loader for the garbler netlist RAM: accepts gate descriptors, checks
// topological order, and serves a 1-cycle-latency lookup port.
module netlist_loader
    import nl_pkg::*;
#(
    parameter int unsigned S = S_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [S-1:0]        cfg_input_size,
    netlist_loader_if.slave     wr,
    output logic                load_done,
    output logic                load_err,
    output logic [1:0]          err_code,
    output logic [S:0]          gate_count,
    output logic [S-1:0]        input_size,
    input  logic [S-1:0]        rd_gid,
    output logic [S-1:0]        rd_in0,
    output logic [S-1:0]        rd_in1,
    output logic [3:0]          rd_logic,
    output logic                rd_in0F,
    output logic                rd_in1F
);

    typedef struct packed {
        logic [S-1:0] in0;
        logic [S-1:0] in1;
        logic [3:0]   truth;
    } gate_w_t;

    state_e       state_q, state_d;
    logic [S-1:0] ptr_q, ptr_d;
    logic [S:0]   gate_count_q, gate_count_d;
    logic [S-1:0] input_size_q, input_size_d;
    logic         load_done_q, load_done_d;
    logic         load_err_q, load_err_d;
    logic [1:0]   err_code_q, err_code_d;

    logic         ram_we;
    gate_w_t      ram_wdata;
    gate_w_t      ram_rdata;
    logic [S:0]   limit;
    logic         desc_ok;

    // A gate may only reference circuit inputs or outputs of earlier gates.
    assign limit   = {1'b0, input_size_q} + {1'b0, ptr_q};
    assign desc_ok = ({1'b0, wr.wr_in0} < limit) && ({1'b0, wr.wr_in1} < limit);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gate_count_d = gate_count_q;
        input_size_d = input_size_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;
        err_code_d   = err_code_q;
        ram_we       = 1'b0;
        ram_wdata    = '{in0: wr.wr_in0, in1: wr.wr_in1, truth: wr.wr_logic};
        wr.wr_ready  = (state_q == ST_LOAD);

        if (abort) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b0;
        end else if (start) begin
            state_d      = ST_LOAD;
            ptr_d        = '0;
            gate_count_d = '0;
            input_size_d = cfg_input_size;
            load_done_d  = 1'b0;
            load_err_d   = 1'b0;
            err_code_d   = ERR_NONE;
        end else if (state_q == ST_LOAD && wr.wr_valid) begin
            if (desc_ok) begin
                ram_we       = 1'b1;
                ptr_d        = ptr_q + S'(1);
                gate_count_d = gate_count_q + (S+1)'(1);
                if (wr.wr_last) begin
                    state_d     = ST_DONE;
                    load_done_d = 1'b1;
                end else if (ptr_q == '1) begin
                    state_d    = ST_ERR;
                    load_err_d = 1'b1;
                    err_code_d = ERR_OVERFLOW;
                end
            end else begin
                state_d    = ST_ERR;
                load_err_d = 1'b1;
                err_code_d = ERR_ORDER;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            gate_count_q <= '0;
            input_size_q <= '0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gate_count_q <= gate_count_d;
            input_size_q <= input_size_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            err_code_q   <= err_code_d;
        end
    end

    nl_ram #(
        .AW(S),
        .DW(2*S + 4)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ptr_q),
        .wdata (ram_wdata),
        .raddr (rd_gid),
        .rdata (ram_rdata)
    );

    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign err_code   = err_code_q;
    assign gate_count = gate_count_q;
    assign input_size = input_size_q;
    assign rd_in0     = ram_rdata.in0;
    assign rd_in1     = ram_rdata.in1;
    assign rd_logic   = ram_rdata.truth;
    assign rd_in0F    = (ram_rdata.in0 < input_size_q);
    assign rd_in1F    = (ram_rdata.in1 < input_size_q);

endmodule

// File: tb/tb_netlist_loader.sv
// Directed bench for netlist_loader at S=4: load, order/overflow errors,
// backpressure gaps, restart/abort and asynchronous reset.
module tb_netlist_loader;

    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [S-1:0] cfg_input_size;
    logic         load_done;
    logic         load_err;
    logic [1:0]   err_code;
    logic [S:0]   gate_count;
    logic [S-1:0] input_size;
    logic [S-1:0] rd_gid;
    logic [S-1:0] rd_in0;
    logic [S-1:0] rd_in1;
    logic [3:0]   rd_logic;
    logic         rd_in0F;
    logic         rd_in1F;

    int total = 0;
    int bad   = 0;

    netlist_loader_if #(.S(S)) wr_if ();

    netlist_loader #(.S(S)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_input_size (cfg_input_size),
        .wr             (wr_if),
        .load_done      (load_done),
        .load_err       (load_err),
        .err_code       (err_code),
        .gate_count     (gate_count),
        .input_size     (input_size),
        .rd_gid         (rd_gid),
        .rd_in0         (rd_in0),
        .rd_in1         (rd_in1),
        .rd_logic       (rd_logic),
        .rd_in0F        (rd_in0F),
        .rd_in1F        (rd_in1F)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [S-1:0] a, input logic [S-1:0] b,
                        input logic [3:0] t, input logic l);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_in0   = a;
        wr_if.wr_in1   = b;
        wr_if.wr_logic = t;
        wr_if.wr_last  = l;
        @(negedge clk);
    endtask

    task automatic idle();
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
    endtask

    task automatic pulse_start(input logic [S-1:0] cfg);
        start          = 1'b1;
        cfg_input_size = cfg;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [S-1:0] g, input logic [S-1:0] e0,
                      input logic [S-1:0] e1, input logic [3:0] et,
                      input logic f0, input logic f1);
        rd_gid = g;
        @(negedge clk);
        chk({tag, "_in0"}, 32'(rd_in0), 32'(e0));
        chk({tag, "_in1"}, 32'(rd_in1), 32'(e1));
        chk({tag, "_logic"}, 32'(rd_logic), 32'(et));
        chk({tag, "_in0F"}, 32'(rd_in0F), 32'(f0));
        chk({tag, "_in1F"}, 32'(rd_in1F), 32'(f1));
    endtask

    initial begin
        logic [15:0] pat;
        int          k;

        rst_n          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        cfg_input_size = '0;
        rd_gid         = '0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_in0   = '0;
        wr_if.wr_in1   = '0;
        wr_if.wr_logic = '0;
        wr_if.wr_last  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(wr_if.wr_ready), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_err", 32'(load_err), 0);
        chk("rst_code", 32'(err_code), 0);
        chk("rst_count", 32'(gate_count), 0);
        chk("rst_isize", 32'(input_size), 0);
        chk("rst_rd_in0", 32'(rd_in0), 0);
        chk("rst_rd_logic", 32'(rd_logic), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(wr_if.wr_ready), 0);

        // Basic three-gate load.
        pulse_start(4);
        chk("load_ready", 32'(wr_if.wr_ready), 1);
        chk("load_isize", 32'(input_size), 4);
        push(0, 1, 4'h8, 1'b0);
        push(2, 3, 4'h6, 1'b0);
        push(4, 5, 4'h1, 1'b1);
        idle();
        chk("basic_done", 32'(load_done), 1);
        chk("basic_count", 32'(gate_count), 3);
        chk("basic_ready", 32'(wr_if.wr_ready), 0);
        rd("g0", 0, 0, 1, 4'h8, 1'b1, 1'b1);
        rd("g1", 1, 2, 3, 4'h6, 1'b1, 1'b1);
        rd("g2", 2, 4, 5, 4'h1, 1'b0, 1'b0);

        push(0, 0, 4'h0, 1'b1);
        idle();
        chk("done_ignore_count", 32'(gate_count), 3);
        chk("done_hold", 32'(load_done), 1);

        // Restart from DONE, overwrite from gid 0, then boundary order violation.
        pulse_start(4);
        chk("restart_done", 32'(load_done), 0);
        chk("restart_count", 32'(gate_count), 0);
        push(3, 0, 4'hA, 1'b0);
        push(1, 4, 4'h2, 1'b0);
        push(0, 6, 4'h3, 1'b0);
        idle();
        chk("ord_b_err", 32'(load_err), 1);
        chk("ord_b_code", 32'(err_code), 1);
        chk("ord_b_count", 32'(gate_count), 2);
        chk("ord_b_ready", 32'(wr_if.wr_ready), 0);
        rd("ow1", 1, 1, 4, 4'h2, 1'b1, 1'b0);
        rd("keep2", 2, 4, 5, 4'h1, 1'b0, 1'b0);

        pulse_start(4);
        chk("start_clr_err", 32'(load_err), 0);
        chk("start_clr_code", 32'(err_code), 0);
        push(4, 0, 4'hF, 1'b0);
        idle();
        chk("ord_err", 32'(load_err), 1);
        chk("ord_code", 32'(err_code), 1);
        chk("ord_count", 32'(gate_count), 0);
        chk("ord_ready", 32'(wr_if.wr_ready), 0);
        rd("ord_ram0", 0, 3, 0, 4'hA, 1'b1, 1'b1);
        pulse_abort();
        chk("abort_err_hold", 32'(load_err), 1);
        chk("abort_code_hold", 32'(err_code), 1);

        // Overflow: 16 valid gates without last.
        pulse_start(2);
        for (int i = 0; i < 15; i++) begin
            push(S'(i), S'(i + 1), 4'(i), 1'b0);
        end
        chk("ovf_pre_count", 32'(gate_count), 15);
        chk("ovf_pre_ready", 32'(wr_if.wr_ready), 1);
        push(15, 0, 4'hF, 1'b0);
        idle();
        chk("ovf_code", 32'(err_code), 2);
        chk("ovf_err", 32'(load_err), 1);
        chk("ovf_count", 32'(gate_count), 16);
        chk("ovf_ready", 32'(wr_if.wr_ready), 0);
        chk("ovf_done", 32'(load_done), 0);
        rd("ovf15", 15, 15, 0, 4'hF, 1'b0, 1'b1);

        // Valid gaps: only handshaked descriptors land in RAM.
        pulse_start(4);
        pat = 16'b1011001011010011;
        k   = 0;
        for (int i = 0; i < 16; i++) begin
            if (pat[i]) begin
                push(S'(k), 0, 4'(k), 1'b0);
                k++;
            end else begin
                wr_if.wr_valid = 1'b0;
                wr_if.wr_in0   = '1;
                wr_if.wr_logic = 4'hE;
                @(negedge clk);
            end
        end
        idle();
        chk("bp_count", 32'(gate_count), 9);
        chk("bp_ready", 32'(wr_if.wr_ready), 1);
        rd("bp8", 8, 8, 0, 4'h8, 1'b0, 1'b1);
        rd("bp3", 3, 3, 0, 4'h3, 1'b1, 1'b1);

        // Abort mid-load, then abort and start together.
        pulse_abort();
        chk("abort_ready", 32'(wr_if.wr_ready), 0);
        chk("abort_done", 32'(load_done), 0);
        chk("abort_count", 32'(gate_count), 9);
        abort          = 1'b1;
        start          = 1'b1;
        cfg_input_size = 7;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abst_ready", 32'(wr_if.wr_ready), 0);
        chk("abst_isize", 32'(input_size), 4);

        // Asynchronous reset between clock edges during a load.
        pulse_start(4);
        push(0, 1, 4'h3, 1'b0);
        idle();
        chk("pre_rst_count", 32'(gate_count), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(wr_if.wr_ready), 0);
        chk("arst_count", 32'(gate_count), 0);
        chk("arst_isize", 32'(input_size), 0);
        chk("arst_done", 32'(load_done), 0);
        chk("arst_rd_in0", 32'(rd_in0), 0);
        chk("arst_rd_logic", 32'(rd_logic), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_ready", 32'(wr_if.wr_ready), 0);
        push(0, 1, 4'h3, 1'b0);
        idle();
        chk("post_rst_count", 32'(gate_count), 0);
        chk("post_rst_ready2", 32'(wr_if.wr_ready), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
